// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- parametrised UART receiver with receive FIFO.
//
// Receives asynchronous serial frames (start, DATA_BITS data LSB first,
// optional parity, STOP_BITS stop bits) and pushes good frames into a small
// first-word-fall-through FIFO. Each bit is a 3-sample majority vote around
// mid-bit. A start bit that does not survive to its sample point is treated
// as a glitch and ignored. Bad frames are dropped and reported on sticky
// flags.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active high
//   rx          serial input, asynchronous, idle high
//   rd_en       pop the FIFO head (ignored while rdy = 0)
//   clr_err     clear parity_err / frame_err / overrun
//   rx_data     FIFO head, valid while rdy = 1
//   rdy         FIFO not empty
//   count       FIFO occupancy, 0..FIFO_DEPTH
//   parity_err  sticky: frame dropped for bad parity
//   frame_err   sticky: frame dropped for a low stop bit
//   overrun     sticky: good frame dropped because the FIFO was full
module uart_rx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rdy,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int MID  = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   MID_M1    = CW'(MID - 1);
    localparam logic [CW-1:0]   MID_C     = CW'(MID);
    localparam logic [CW-1:0]   MID_P1    = CW'(MID + 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // Majority of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // True when the received parity bit matches the configured mode.
    function automatic logic parity_good(input logic [DATA_BITS-1:0] d, input logic p);
        if (PARITY == 2) begin
            return ((^d) ^ p) == 1'b1;
        end else begin
            return ((^d) ^ p) == 1'b0;
        end
    endfunction

    state_t                 state_r, state_next_s;
    logic                   rx_meta_r, rx_sync_r, rx_prev_r;
    logic [1:0]             sync_vld_r;
    logic [CW-1:0]          cnt_r;
    logic                   vote0_r, vote1_r;
    logic [3:0]             bit_idx_r;
    logic                   stop_idx_r;
    logic                   stop_ok_r, par_ok_r;
    logic [DATA_BITS-1:0]   shift_r;

    logic [DATA_BITS-1:0]   mem_r [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_r, rd_ptr_r;
    logic [CNTW-1:0]        count_r;
    logic                   rdy_r;
    logic [DATA_BITS-1:0]   rx_data_r;
    logic                   parity_err_r, frame_err_r, overrun_r;

    logic                   edge_s, sample_tick_s, sample_s, frame_done_s;
    logic                   stop_good_s, pop_s, full_s;
    logic                   push_s, set_frame_s, set_par_s, set_ovr_s;
    logic [CNTW-1:0]        count_next_s;
    logic [DATA_BITS-1:0]   head_next_s;
    logic [PW-1:0]          rd_ptr_inc_s;

    // Two-flop synchroniser plus edge history. The edge history only follows
    // the line once both synchroniser stages hold real line samples, so a line
    // that is already low when reset releases never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            sync_vld_r <= 2'b00;
            rx_prev_r  <= 1'b0;
        end else begin
            rx_meta_r  <= rx;
            rx_sync_r  <= rx_meta_r;
            sync_vld_r <= {sync_vld_r[0], 1'b1};
            rx_prev_r  <= sync_vld_r[1] ? rx_sync_r : 1'b0;
        end
    end

    assign edge_s        = rx_prev_r & ~rx_sync_r;
    assign sample_tick_s = (cnt_r == MID_P1);
    assign sample_s      = maj3(vote0_r, vote1_r, rx_sync_r);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; frame_done_s marks the last stop-bit sample (cycle T).
    always_comb begin
        state_next_s = state_r;
        frame_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (edge_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (sample_tick_s) begin
                    state_next_s = sample_s ? ST_IDLE : ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (sample_tick_s && (bit_idx_r == DATA_LAST)) begin
                    if (PARITY != 0) begin
                        state_next_s = ST_PAR;
                    end else begin
                        state_next_s = ST_STOP;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PAR: begin
                if (sample_tick_s) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PAR;
                end
            end
            ST_STOP: begin
                if (sample_tick_s && (stop_idx_r == STOP_LAST)) begin
                    state_next_s = ST_IDLE;
                    frame_done_s = 1'b1;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Baud counter: held at zero in IDLE, wraps at every bit boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if ((state_r == ST_IDLE) || (state_next_s == ST_IDLE) || (cnt_r == CNT_LAST)) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // The first two of the three majority-vote samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            vote0_r <= 1'b1;
            vote1_r <= 1'b1;
        end else begin
            vote0_r <= (cnt_r == MID_M1) ? rx_sync_r : vote0_r;
            vote1_r <= (cnt_r == MID_C)  ? rx_sync_r : vote1_r;
        end
    end

    // Per-frame datapath: data shifter, bit indices, parity and stop status.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx_r  <= 4'd0;
            stop_idx_r <= 1'b0;
            stop_ok_r  <= 1'b1;
            par_ok_r   <= 1'b1;
            shift_r    <= {DATA_BITS{1'b0}};
        end else if (state_r == ST_IDLE) begin
            bit_idx_r  <= 4'd0;
            stop_idx_r <= 1'b0;
            stop_ok_r  <= 1'b1;
            par_ok_r   <= 1'b1;
        end else if (sample_tick_s) begin
            case (state_r)
                ST_DATA: begin
                    shift_r   <= {sample_s, shift_r[DATA_BITS-1:1]};
                    bit_idx_r <= bit_idx_r + 4'd1;
                end
                ST_PAR: begin
                    par_ok_r <= parity_good(shift_r, sample_s);
                end
                ST_STOP: begin
                    stop_ok_r  <= stop_ok_r & sample_s;
                    stop_idx_r <= stop_idx_r + 1'b1;
                end
                default: begin
                    bit_idx_r <= bit_idx_r;
                end
            endcase
        end
    end

    // Frame disposition at cycle T: frame error beats parity beats overrun.
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign stop_good_s = stop_ok_r & sample_s;
    assign pop_s       = rd_en & rdy_r;
    assign full_s      = (count_r == FULL_CNT);
    assign set_frame_s = frame_done_s & ~stop_good_s;
    assign set_par_s   = frame_done_s & stop_good_s & ~par_ok_r;
    assign set_ovr_s   = frame_done_s & stop_good_s & par_ok_r & full_s & ~pop_s;
    assign push_s      = frame_done_s & stop_good_s & par_ok_r & (~full_s | pop_s);
    assign rd_ptr_inc_s = rd_ptr_r + PW'(1);

    // Next occupancy and next head word for the registered FIFO outputs.
    always_comb begin
        count_next_s = count_r;
        head_next_s  = rx_data_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CNTW'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNTW'(1);
        end else begin
            count_next_s = count_r;
        end
        // The pushed word becomes head when the FIFO is (or is becoming) empty.
        if (push_s && ((count_r == CNTW'(0)) || (pop_s && (count_r == CNTW'(1))))) begin
            head_next_s = shift_r;
        end else if (pop_s && (count_r > CNTW'(1))) begin
            head_next_s = mem_r[rd_ptr_inc_s];
        end else begin
            head_next_s = rx_data_r;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            count_r   <= {CNTW{1'b0}};
            rdy_r     <= 1'b0;
            rx_data_r <= {DATA_BITS{1'b0}};
        end else begin
            wr_ptr_r  <= push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
            rd_ptr_r  <= pop_s ? rd_ptr_inc_s : rd_ptr_r;
            count_r   <= count_next_s;
            rdy_r     <= (count_next_s != CNTW'(0));
            rx_data_r <= head_next_s;
        end
    end

    // Sticky error flags; a new error wins over clr_err in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            parity_err_r <= set_par_s   ? 1'b1 : (clr_err ? 1'b0 : parity_err_r);
            frame_err_r  <= set_frame_s ? 1'b1 : (clr_err ? 1'b0 : frame_err_r);
            overrun_r    <= set_ovr_s   ? 1'b1 : (clr_err ? 1'b0 : overrun_r);
        end
    end

    assign rx_data    = rx_data_r;
    assign rdy        = rdy_r;
    assign count      = count_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo: an 8N1 instance (a) and a
// 7-bit even-parity two-stop instance (b), both at 16 clocks per bit.
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx_a, rd_en_a, clr_err_a;
    logic [7:0] rx_data_a;
    logic       rdy_a, parity_err_a, frame_err_a, overrun_a;
    logic [2:0] count_a;
    logic       rx_b, rd_en_b, clr_err_b;
    logic [6:0] rx_data_b;
    logic       rdy_b, parity_err_b, frame_err_b, overrun_b;
    logic [2:0] count_b;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_fifo #(
        .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .rd_en(rd_en_a), .clr_err(clr_err_a),
        .rx_data(rx_data_a), .rdy(rdy_a), .count(count_a),
        .parity_err(parity_err_a), .frame_err(frame_err_a), .overrun(overrun_a)
    );

    uart_rx_fifo #(
        .DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u_dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .rd_en(rd_en_b), .clr_err(clr_err_b),
        .rx_data(rx_data_b), .rdy(rdy_b), .count(count_b),
        .parity_err(parity_err_b), .frame_err(frame_err_b), .overrun(overrun_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] f8n1(input logic [7:0] d, input logic stop);
        logic [15:0] f;
        f = 16'h0000;
        f[8:1] = d;
        f[9] = stop;
        return f;
    endfunction

    function automatic logic [15:0] f7e2(input logic [6:0] d, input logic p);
        logic [15:0] f;
        f = 16'h0000;
        f[7:1] = d;
        f[8] = p;
        f[10:9] = 2'b11;
        return f;
    endfunction

    // Drive len bits (bit 0 first), CPB clocks each, from negedge to negedge.
    // glitch_bit >= 0 inverts that bit for one clock at its middle.
    // pop_t pulses rd_en_a in the last-stop-bit sample cycle of instance a.
    task automatic drive_frame(input int sel, input logic [15:0] bits, input int len,
                               input int glitch_bit, input bit pop_t);
        logic v;
        for (int i = 0; i < len; i++) begin
            for (int j = 0; j < CPB; j++) begin
                v = bits[i];
                if (i == glitch_bit && j == CPB / 2) v = ~v;
                if (sel == 0) rx_a = v; else rx_b = v;
                rd_en_a = (pop_t && i == len - 1 && j == 12) ? 1'b1 : 1'b0;
                @(negedge clk);
            end
        end
        rd_en_a = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] d);
        drive_frame(0, f8n1(d, 1'b1), 10, -1, 1'b0);
    endtask

    task automatic pop_a(input string tag, input logic [7:0] exp);
        check_eq(tag, {24'h0, rx_data_a}, {24'h0, exp});
        rd_en_a = 1'b1;
        @(negedge clk);
        rd_en_a = 1'b0;
    endtask

    task automatic clr_a();
        clr_err_a = 1'b1;
        @(negedge clk);
        clr_err_a = 1'b0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        rx_a = 1'b1; rd_en_a = 1'b0; clr_err_a = 1'b0;
        rx_b = 1'b1; rd_en_b = 1'b0; clr_err_b = 1'b0;
        wait_clks(4);
        rst = 1'b0;
        check_eq("reset_rdy",      {31'h0, rdy_a}, 32'h0);
        check_eq("reset_count",    {29'h0, count_a}, 32'h0);
        check_eq("reset_data",     {24'h0, rx_data_a}, 32'h0);
        check_eq("reset_flags",    {29'h0, parity_err_a, frame_err_a, overrun_a}, 32'h0);
        check_eq("reset_count_b",  {29'h0, count_b}, 32'h0);
        wait_clks(20);

        // 1. back-to-back 8N1 frames
        send_a(8'hA5);
        send_a(8'h3C);
        wait_clks(2);
        check_eq("t1_count2", {29'h0, count_a}, 32'd2);
        pop_a("t1_head_a5", 8'hA5);
        check_eq("t1_head_3c", {24'h0, rx_data_a}, 32'h3C);
        pop_a("t1_pop_3c", 8'h3C);
        check_eq("t1_empty", {31'h0, rdy_a}, 32'h0);
        check_eq("t1_count0", {29'h0, count_a}, 32'd0);
        rd_en_a = 1'b1;
        @(negedge clk);
        rd_en_a = 1'b0;
        check_eq("t1_no_underflow", {29'h0, count_a}, 32'd0);

        // 2. 7 data bits, even parity, 2 stop bits: 0x55 has four ones -> p = 0
        drive_frame(1, f7e2(7'h55, 1'b0), 11, -1, 1'b0);
        wait_clks(2);
        check_eq("t2_push_count", {29'h0, count_b}, 32'd1);
        check_eq("t2_push_data", {25'h0, rx_data_b}, 32'h55);
        check_eq("t2_no_perr", {31'h0, parity_err_b}, 32'h0);
        drive_frame(1, f7e2(7'h55, 1'b1), 11, -1, 1'b0);
        wait_clks(2);
        check_eq("t2_bad_count", {29'h0, count_b}, 32'd1);
        check_eq("t2_perr_set", {31'h0, parity_err_b}, 32'h1);
        check_eq("t2_ferr_clear", {31'h0, frame_err_b}, 32'h0);
        clr_err_b = 1'b1;
        @(negedge clk);
        clr_err_b = 1'b0;
        check_eq("t2_perr_cleared", {31'h0, parity_err_b}, 32'h0);

        // 3. low stop bit, then a break
        drive_frame(0, f8n1(8'h81, 1'b0), 10, -1, 1'b0);
        rx_a = 1'b1;
        wait_clks(CPB);
        check_eq("t3_stop_count", {29'h0, count_a}, 32'd0);
        check_eq("t3_ferr", {31'h0, frame_err_a}, 32'h1);
        check_eq("t3_other_flags", {30'h0, parity_err_a, overrun_a}, 32'h0);
        clr_a();
        check_eq("t3_ferr_cleared", {31'h0, frame_err_a}, 32'h0);
        rx_a = 1'b0;
        wait_clks(3 * 10 * CPB);
        check_eq("t3_break_ferr", {31'h0, frame_err_a}, 32'h1);
        check_eq("t3_break_count", {29'h0, count_a}, 32'd0);
        clr_a();
        wait_clks(10 * CPB);
        check_eq("t3_break_once", {31'h0, frame_err_a}, 32'h0);
        rx_a = 1'b1;
        wait_clks(2 * CPB);
        check_eq("t3_break_release", {30'h0, frame_err_a, rdy_a}, 32'h0);

        // 4. short low pulse in IDLE, then a glitch on a data-bit sample
        rx_a = 1'b0;
        wait_clks(4);
        rx_a = 1'b1;
        wait_clks(3 * CPB);
        check_eq("t4_pulse_count", {29'h0, count_a}, 32'd0);
        check_eq("t4_pulse_flags", {29'h0, parity_err_a, frame_err_a, overrun_a}, 32'h0);
        drive_frame(0, f8n1(8'hF0, 1'b1), 10, 5, 1'b0);
        wait_clks(2);
        check_eq("t4_glitch_count", {29'h0, count_a}, 32'd1);
        pop_a("t4_glitch_data", 8'hF0);
        check_eq("t4_glitch_flags", {29'h0, parity_err_a, frame_err_a, overrun_a}, 32'h0);

        // 5. overrun, then the same with a pop in the fifth frame's cycle T
        send_a(8'h11); send_a(8'h22); send_a(8'h33); send_a(8'h44); send_a(8'h55);
        wait_clks(2);
        check_eq("t5_full_count", {29'h0, count_a}, 32'd4);
        check_eq("t5_overrun", {31'h0, overrun_a}, 32'h1);
        pop_a("t5_head_11", 8'h11);
        pop_a("t5_pop_22", 8'h22);
        pop_a("t5_pop_33", 8'h33);
        pop_a("t5_pop_44", 8'h44);
        check_eq("t5_drained", {31'h0, rdy_a}, 32'h0);
        clr_a();
        check_eq("t5_ovr_cleared", {31'h0, overrun_a}, 32'h0);
        send_a(8'h66); send_a(8'h77); send_a(8'h88); send_a(8'h99);
        drive_frame(0, f8n1(8'hAA, 1'b1), 10, -1, 1'b1);
        wait_clks(2);
        check_eq("t5_pop_t_count", {29'h0, count_a}, 32'd4);
        check_eq("t5_pop_t_no_ovr", {31'h0, overrun_a}, 32'h0);
        pop_a("t5_pop_77", 8'h77);
        pop_a("t5_pop_88", 8'h88);
        pop_a("t5_pop_99", 8'h99);
        pop_a("t5_pop_aa", 8'hAA);
        check_eq("t5_empty", {29'h0, count_a}, 32'd0);

        // 6. reset mid-frame with a non-empty FIFO and a flag set
        drive_frame(0, f8n1(8'h00, 1'b0), 10, -1, 1'b0);
        rx_a = 1'b1;
        wait_clks(CPB);
        send_a(8'h01);
        send_a(8'h02);
        wait_clks(2);
        check_eq("t6_pre_count", {29'h0, count_a}, 32'd2);
        check_eq("t6_pre_ferr", {31'h0, frame_err_a}, 32'h1);
        rx_a = 1'b0; wait_clks(CPB);     // start
        rx_a = 1'b0; wait_clks(CPB);     // data bit 0 of 0x12
        rx_a = 1'b1; wait_clks(CPB);     // data bit 1
        rx_a = 1'b0; wait_clks(CPB / 2); // middle of data bit 2
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_rst_count", {29'h0, count_a}, 32'd0);
        check_eq("t6_rst_rdy", {31'h0, rdy_a}, 32'h0);
        check_eq("t6_rst_flags", {29'h0, parity_err_a, frame_err_a, overrun_a}, 32'h0);
        check_eq("t6_rst_data", {24'h0, rx_data_a}, 32'h0);
        wait_clks(CPB / 2);
        rx_a = 1'b1;
        wait_clks(3 * CPB);
        check_eq("t6_no_spurious", {29'h0, count_a}, 32'd0);
        send_a(8'h34);
        wait_clks(4);
        check_eq("t6_after_count", {29'h0, count_a}, 32'd1);
        check_eq("t6_after_data", {24'h0, rx_data_a}, 32'h34);
        check_eq("t6_after_flags", {29'h0, parity_err_a, frame_err_a, overrun_a}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
